// File: rtl/mc_ctrl_unit.sv
// Multicycle IF/ID/EXE/MEM/WB sequencer for the MIPS-subset datapath.
// Drives ALU op, operand selects and write enables; memory waits time out.
module mc_ctrl_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic [3:0] aluc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [1:0] pcsrc,
  output logic       wpc,
  output logic       wir,
  output logic       wtgt,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic [2:0] state,
  output logic       ill,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  localparam logic [3:0] A_ADD = 4'b0000;
  localparam logic [3:0] A_SUB = 4'b0100;
  localparam logic [3:0] A_AND = 4'b0001;
  localparam logic [3:0] A_OR  = 4'b0101;
  localparam logic [3:0] A_XOR = 4'b0010;
  localparam logic [3:0] A_LUI = 4'b0110;
  localparam logic [3:0] A_SLL = 4'b0011;
  localparam logic [3:0] A_SRL = 4'b0111;
  localparam logic [3:0] A_SRA = 4'b1111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;

  state_t     r_state;
  state_t     w_nstate;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  logic       w_rtype;
  logic       w_lw;
  logic       w_sw;
  logic       w_beq;
  logic       w_bne;
  logic       w_j;
  logic       w_valid;
  logic       w_shift;
  logic       w_sxt;
  logic [3:0] w_dec_aluc;
  logic       w_to;

  assign w_rtype = (op == OP_R);
  assign w_lw    = (op == OP_LW);
  assign w_sw    = (op == OP_SW);
  assign w_beq   = (op == OP_BEQ);
  assign w_bne   = (op == OP_BNE);
  assign w_j     = (op == OP_J);
  assign w_to    = (r_cnt == TO_CNT);
  assign state   = r_state;

  always_comb begin
    w_valid    = 1'b0;
    w_shift    = 1'b0;
    w_sxt      = 1'b0;
    w_dec_aluc = A_ADD;
    if (w_rtype) begin
      case (func)
        F_ADD: begin w_valid = 1'b1; w_dec_aluc = A_ADD; end
        F_SUB: begin w_valid = 1'b1; w_dec_aluc = A_SUB; end
        F_AND: begin w_valid = 1'b1; w_dec_aluc = A_AND; end
        F_OR:  begin w_valid = 1'b1; w_dec_aluc = A_OR;  end
        F_XOR: begin w_valid = 1'b1; w_dec_aluc = A_XOR; end
        F_SLL: begin
          w_valid = 1'b1; w_shift = 1'b1; w_dec_aluc = A_SLL;
        end
        F_SRL: begin
          w_valid = 1'b1; w_shift = 1'b1; w_dec_aluc = A_SRL;
        end
        F_SRA: begin
          w_valid = 1'b1; w_shift = 1'b1; w_dec_aluc = A_SRA;
        end
        default: ;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_LW, OP_SW: begin
          w_valid = 1'b1; w_sxt = 1'b1; w_dec_aluc = A_ADD;
        end
        OP_ANDI: begin w_valid = 1'b1; w_dec_aluc = A_AND; end
        OP_ORI:  begin w_valid = 1'b1; w_dec_aluc = A_OR;  end
        OP_XORI: begin w_valid = 1'b1; w_dec_aluc = A_XOR; end
        OP_LUI:  begin w_valid = 1'b1; w_dec_aluc = A_LUI; end
        OP_BEQ, OP_BNE: begin
          w_valid = 1'b1; w_sxt = 1'b1; w_dec_aluc = A_SUB;
        end
        OP_J: w_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    aluc      = A_ADD;
    alusrca   = 2'd0;
    alusrcb   = 2'd0;
    sext      = 1'b0;
    pcsrc     = 2'd0;
    wpc       = 1'b0;
    wir       = 1'b0;
    wtgt      = 1'b0;
    wmem      = 1'b0;
    wreg      = 1'b0;
    iord      = 1'b0;
    regrt     = 1'b0;
    m2reg     = 1'b0;
    ill       = 1'b0;
    bus_err   = 1'b0;
    w_nstate  = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IF: begin
        alusrcb = 2'd1;
        if (mem_rdy) begin
          wir       = 1'b1;
          wpc       = 1'b1;
          w_cnt_nxt = '0;
          w_nstate  = S_ID;
        end else if (w_to) begin
          bus_err   = 1'b1;
          w_cnt_nxt = '0;
          w_nstate  = S_IF;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_ID: begin
        alusrcb  = 2'd3;
        sext     = 1'b1;
        w_nstate = S_IF;
        if (!w_valid) begin
          ill = 1'b1;
        end else begin
          wtgt = 1'b1;
          if (w_j) begin
            wpc   = 1'b1;
            pcsrc = 2'd3;
          end else begin
            w_nstate = S_EXE;
          end
        end
      end
      S_EXE: begin
        alusrca  = w_shift ? 2'd2 : 2'd1;
        alusrcb  = w_rtype ? 2'd0 : 2'd2;
        sext     = w_sxt;
        aluc     = w_dec_aluc;
        w_nstate = S_IF;
        // Branch target was latched into the target reg during ID.
        if (w_beq || w_bne) begin
          pcsrc = 2'd1;
          wpc   = w_beq ? z : !z;
        end else if (w_lw || w_sw) begin
          w_nstate = S_MEM;
        end else if (w_valid) begin
          w_nstate = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        wmem = w_sw;
        if (mem_rdy) begin
          w_cnt_nxt = '0;
          w_nstate  = w_lw ? S_WB : S_IF;
        end else if (w_to) begin
          wmem      = 1'b0;
          bus_err   = 1'b1;
          w_cnt_nxt = '0;
          w_nstate  = S_IF;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_WB: begin
        wreg     = 1'b1;
        regrt    = !w_rtype;
        m2reg    = w_lw;
        w_nstate = S_IF;
      end
      default: begin
        w_cnt_nxt = '0;
        w_nstate  = S_IF;
      end
    endcase
    // The reset cycle is a dead cycle: nothing may be written.
    if (rst) begin
      aluc    = A_ADD;
      alusrca = 2'd0;
      alusrcb = 2'd0;
      sext    = 1'b0;
      pcsrc   = 2'd0;
      wpc     = 1'b0;
      wir     = 1'b0;
      wtgt    = 1'b0;
      wmem    = 1'b0;
      wreg    = 1'b0;
      iord    = 1'b0;
      regrt   = 1'b0;
      m2reg   = 1'b0;
      ill     = 1'b0;
      bus_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit with TIMEOUT=3.
// Each task drives one scenario and checks outputs a little after the edge.
module tb_mc_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_rdy;
  logic [3:0] aluc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic       sext;
  logic [1:0] pcsrc;
  logic       wpc;
  logic       wir;
  logic       wtgt;
  logic       wmem;
  logic       wreg;
  logic       iord;
  logic       regrt;
  logic       m2reg;
  logic [2:0] state;
  logic       ill;
  logic       bus_err;

  int n_vec = 0;
  int n_err = 0;

  mc_ctrl_unit #(.TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .z(z),
    .mem_rdy(mem_rdy), .aluc(aluc), .alusrca(alusrca),
    .alusrcb(alusrcb), .sext(sext), .pcsrc(pcsrc), .wpc(wpc),
    .wir(wir), .wtgt(wtgt), .wmem(wmem), .wreg(wreg),
    .iord(iord), .regrt(regrt), .m2reg(m2reg), .state(state),
    .ill(ill), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  logic [22:0] allout;
  assign allout = {aluc, alusrca, alusrcb, sext, pcsrc, wpc, wir,
                   wtgt, wmem, wreg, iord, regrt, m2reg, ill, bus_err};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 6'b0; func = 6'b0; z = 1'b0; mem_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      if ({state, allout} !== 26'd0) begin
        $display("FAIL reset%0d got st=%0d out=%h want 0", i, state, allout);
        n_err++;
      end
      n_vec++;
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    op = 6'b000000; func = 6'b100000; mem_rdy = 1'b1; #1;
    if ({state, wir, wpc, iord, alusrcb} !== {3'd0, 3'b110, 2'd1}) begin
      $display("FAIL add_if got %b want 00011001",
               {state, wir, wpc, iord, alusrcb});
      n_err++;
    end
    n_vec++;
    cyc();
    if ({state, wtgt, alusrcb, sext} !== {3'd1, 1'b1, 2'd3, 1'b1}) begin
      $display("FAIL add_id got %b want 0011111",
               {state, wtgt, alusrcb, sext});
      n_err++;
    end
    n_vec++;
    cyc();
    if ({state, aluc, alusrca, alusrcb} !== {3'd2, 4'b0000, 2'd1, 2'd0}) begin
      $display("FAIL add_exe got %b want 010000000100",
               {state, aluc, alusrca, alusrcb});
      n_err++;
    end
    n_vec++;
    cyc();
    if ({state, wreg, regrt, m2reg} !== {3'd4, 3'b100}) begin
      $display("FAIL add_wb got %b want 100100", {state, wreg, regrt, m2reg});
      n_err++;
    end
    n_vec++;
    cyc();
    if (state !== 3'd0) begin
      $display("FAIL add_done got %0d want 0", state);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_shift();
    logic [5:0] fn [2] = '{6'b000010, 6'b000011};
    logic [3:0] ex [2] = '{4'b0111, 4'b1111};
    for (int i = 0; i < 2; i++) begin
      op = 6'b000000; func = fn[i]; mem_rdy = 1'b1; #1;
      cyc();
      cyc();
      if ({state, alusrca, alusrcb, aluc} !== {3'd2, 2'd2, 2'd0, ex[i]}) begin
        $display("FAIL shift%0d_exe got %b want %b", i,
                 {state, alusrca, alusrcb, aluc}, {3'd2, 2'd2, 2'd0, ex[i]});
        n_err++;
      end
      n_vec++;
      cyc();
      cyc();
    end
  endtask

  task automatic test_imm();
    op = 6'b001101; func = 6'b111111; mem_rdy = 1'b1; #1;
    cyc();
    cyc();
    if ({alusrca, alusrcb, sext, aluc} !== {2'd1, 2'd2, 1'b0, 4'b0101}) begin
      $display("FAIL ori_exe got %b want 011000101",
               {alusrca, alusrcb, sext, aluc});
      n_err++;
    end
    n_vec++;
    cyc();
    if ({state, wreg, regrt, m2reg} !== {3'd4, 3'b110}) begin
      $display("FAIL ori_wb got %b want 100110", {state, wreg, regrt, m2reg});
      n_err++;
    end
    n_vec++;
    cyc();
  endtask

  task automatic test_branch();
    logic [5:0] ops [3] = '{6'b000100, 6'b000101, 6'b000101};
    logic       zs  [3] = '{1'b1, 1'b1, 1'b0};
    logic       ew  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      op = ops[i]; z = zs[i]; mem_rdy = 1'b1; #1;
      cyc();
      cyc();
      if ({state, wpc, pcsrc, aluc, sext} !==
          {3'd2, ew[i], 2'd1, 4'b0100, 1'b1}) begin
        $display("FAIL br%0d_exe got %b want %b", i,
                 {state, wpc, pcsrc, aluc, sext},
                 {3'd2, ew[i], 2'd1, 4'b0100, 1'b1});
        n_err++;
      end
      n_vec++;
      cyc();
      if ({state, wpc} !== 4'd0 && state !== 3'd0) begin
        $display("FAIL br%0d_next got st=%0d want 0", i, state);
        n_err++;
      end
      n_vec++;
    end
    z = 1'b0;
  endtask

  task automatic test_j();
    op = 6'b000010; mem_rdy = 1'b1; #1;
    cyc();
    if ({state, wpc, pcsrc, ill} !== {3'd1, 1'b1, 2'd3, 1'b0}) begin
      $display("FAIL j_id got %b want 0011110", {state, wpc, pcsrc, ill});
      n_err++;
    end
    n_vec++;
    cyc();
    if (state !== 3'd0) begin
      $display("FAIL j_next got %0d want 0", state);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_lw_wait();
    op = 6'b100011; mem_rdy = 1'b1; #1;
    cyc();
    cyc();
    if ({state, alusrca, alusrcb, sext, aluc} !==
        {3'd2, 2'd1, 2'd2, 1'b1, 4'b0000}) begin
      $display("FAIL lw_exe got %b want 010011010000",
               {state, alusrca, alusrcb, sext, aluc});
      n_err++;
    end
    n_vec++;
    mem_rdy = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_rdy = 1'b1; #1; end
      if ({state, iord, wmem, bus_err} !== {3'd3, 3'b100}) begin
        $display("FAIL lw_mem%0d got %b want 011100", i,
                 {state, iord, wmem, bus_err});
        n_err++;
      end
      n_vec++;
      cyc();
    end
    if ({state, wreg, regrt, m2reg} !== {3'd4, 3'b111}) begin
      $display("FAIL lw_wb got %b want 100111", {state, wreg, regrt, m2reg});
      n_err++;
    end
    n_vec++;
    cyc();
  endtask

  task automatic test_sw_wait();
    op = 6'b101011; mem_rdy = 1'b1; #1;
    cyc();
    cyc();
    mem_rdy = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_rdy = 1'b1; #1; end
      if ({state, iord, wmem, bus_err} !== {3'd3, 3'b110}) begin
        $display("FAIL sw_mem%0d got %b want 011110", i,
                 {state, iord, wmem, bus_err});
        n_err++;
      end
      n_vec++;
      cyc();
    end
    if ({state, wmem, wreg} !== 5'd0) begin
      $display("FAIL sw_done got %b want 00000", {state, wmem, wreg});
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_timeout();
    op = 6'b000000; func = 6'b100000; mem_rdy = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      if ({state, bus_err, wir, wpc} !== 6'd0) begin
        $display("FAIL to_if%0d got %b want 000000", i,
                 {state, bus_err, wir, wpc});
        n_err++;
      end
      n_vec++;
      cyc();
    end
    if ({state, bus_err, wir, wpc} !== {3'd0, 3'b100}) begin
      $display("FAIL to_pulse got %b want 000100", {state, bus_err, wir, wpc});
      n_err++;
    end
    n_vec++;
    cyc();
    if ({state, bus_err} !== 4'd0) begin
      $display("FAIL to_after got %b want 0000", {state, bus_err});
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_timeout_edge();
    for (int i = 0; i < 3; i++) cyc();
    mem_rdy = 1'b1; #1;
    if ({state, bus_err, wir, wpc} !== {3'd0, 3'b011}) begin
      $display("FAIL to_edge got %b want 000011", {state, bus_err, wir, wpc});
      n_err++;
    end
    n_vec++;
    cyc();
    if (state !== 3'd1) begin
      $display("FAIL to_edge_id got %0d want 1", state);
      n_err++;
    end
    n_vec++;
    repeat (3) cyc();
  endtask

  task automatic test_mem_timeout();
    op = 6'b101011; mem_rdy = 1'b1; #1;
    cyc();
    cyc();
    mem_rdy = 1'b0;
    cyc();
    repeat (3) cyc();
    if ({state, bus_err, wmem} !== {3'd3, 2'b10}) begin
      $display("FAIL memto_pulse got %b want 01110", {state, bus_err, wmem});
      n_err++;
    end
    n_vec++;
    cyc();
    if ({state, bus_err, wmem} !== 5'd0) begin
      $display("FAIL memto_after got %b want 00000", {state, bus_err, wmem});
      n_err++;
    end
    n_vec++;
    mem_rdy = 1'b1;
  endtask

  task automatic test_ill();
    logic [5:0] ops [2] = '{6'b111111, 6'b000000};
    for (int i = 0; i < 2; i++) begin
      op = ops[i]; func = 6'b111111; mem_rdy = 1'b1; #1;
      cyc();
      if ({state, ill, wtgt, wpc, wir, wreg, wmem} !== {3'd1, 6'b100000}) begin
        $display("FAIL ill%0d_id got %b want 001100000", i,
                 {state, ill, wtgt, wpc, wir, wreg, wmem});
        n_err++;
      end
      n_vec++;
      cyc();
      if ({state, ill} !== 4'd0) begin
        $display("FAIL ill%0d_next got %b want 0000", i, {state, ill});
        n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_rst_mid();
    op = 6'b101011; mem_rdy = 1'b1; #1;
    cyc();
    cyc();
    mem_rdy = 1'b0;
    cyc();
    if ({state, wmem} !== {3'd3, 1'b1}) begin
      $display("FAIL rstmid_mem got %b want 0111", {state, wmem});
      n_err++;
    end
    n_vec++;
    rst = 1'b1; #1;
    if (allout !== 23'd0) begin
      $display("FAIL rstmid_gate got %h want 0", allout);
      n_err++;
    end
    n_vec++;
    cyc();
    rst = 1'b0; #1;
    if ({state, wmem, wir, bus_err} !== 6'd0) begin
      $display("FAIL rstmid_next got %b want 000000",
               {state, wmem, wir, bus_err});
      n_err++;
    end
    n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_imm();
    test_branch();
    test_j();
    test_lw_wait();
    test_sw_wait();
    test_timeout();
    test_timeout_edge();
    test_mem_timeout();
    test_ill();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
